coletor_votos: RTL and testbench

Vote-collection block for the werewolf game: after roles are dealt, it walks the living players in index order, takes one confirmed vote from each, tallies the votes and reports who is eliminated. It sits beside the role-dealing datapath and is driven by the same debounced, edge-detected buttons. It reports `jogador_atual`-style indices and a 5-bit `db_estado` for the 7-segment debug displays.

---
 rtl/coletor_votos_pkg.sv | 14 +
 rtl/coletor_votos_if.sv | 22 ++
 rtl/coletor_votos_placar_votos.sv | 21 ++
 rtl/coletor_votos.sv | 151 +++++++++++++++
 tb/tb_coletor_votos.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/coletor_votos_pkg.sv
// coletor_votos_pkg: shared constants and FSM state codes for the vote collector
package coletor_votos_pkg;
  localparam int N_JOGADORES_PADRAO = 8;
  localparam int CONT_W = 4;
  localparam int IDX_W = 3;
  typedef enum logic [4:0] {
    INICIAL  = 5'd0,
    PREPARA  = 5'd1,
    AGUARDA  = 5'd2,
    REGISTRA = 5'd3,
    APURA    = 5'd4,
    FIM      = 5'd5
  } estado_t;
endpackage

// File: rtl/coletor_votos_if.sv
// coletor_votos_if: button/switch inputs and registered result outputs of the vote collector
interface coletor_votos_if #(parameter int N = coletor_votos_pkg::N_JOGADORES_PADRAO);
  logic                               iniciar;
  logic [N-1:0]                       vivos;
  logic [coletor_votos_pkg::IDX_W-1:0] voto;
  logic                               abstem;
  logic                               confirma;
  logic [coletor_votos_pkg::IDX_W-1:0] eleitor_atual;
  logic                               voto_invalido;
  logic                               pronto;
  logic [coletor_votos_pkg::IDX_W-1:0] eliminado;
  logic                               empate;
  logic [4:0]                         db_estado;
  modport master (
    output iniciar, vivos, voto, abstem, confirma,
    input  eleitor_atual, voto_invalido, pronto, eliminado, empate, db_estado
  );
  modport slave (
    input  iniciar, vivos, voto, abstem, confirma,
    output eleitor_atual, voto_invalido, pronto, eliminado, empate, db_estado
  );
endinterface

// File: rtl/coletor_votos_placar_votos.sv
// placar_votos: per-player vote counters with sync clear, one increment port and one read port
module placar_votos
  import coletor_votos_pkg::*;
#(
  parameter int N = N_JOGADORES_PADRAO
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              inc_i,
  input  logic [IDX_W-1:0]  inc_idx_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [CONT_W-1:0] rd_cnt_o
);
  logic [CONT_W-1:0] cnt_q [N];
  always_ff @(posedge clk)
    for (int i = 0; i < N; i++)
      if (rst || clr_i) cnt_q[i] <= '0;
      else if (inc_i && inc_idx_i == IDX_W'(i)) cnt_q[i] <= cnt_q[i] + 1'b1;
  assign rd_cnt_o = cnt_q[rd_idx_i];
endmodule

// File: rtl/coletor_votos.sv
// coletor_votos: walks living players, collects one confirmed vote each, tallies and reports the eliminated player.
// Optional abstention on confirm is enabled by defining COLETOR_ABSTENCAO_EN.
module coletor_votos
  import coletor_votos_pkg::*;
#(
  parameter int N_JOGADORES = N_JOGADORES_PADRAO
) (
  input logic            clock,
  input logic            reset,
  coletor_votos_if.slave bus
);
  estado_t               est_q, est_d;
  logic [N_JOGADORES-1:0] mask_q, mask_d;
  logic [IDX_W-1:0]      eleitor_q, eleitor_d, voto_q, voto_d, idx_q, idx_d;
  logic [IDX_W-1:0]      best_q, best_d, elim_q, elim_d;
  logic [CONT_W-1:0]     max_q, max_d, cnt;
  logic                  abst_q, abst_d, inval_q, inval_d, pronto_q, pronto_d;
  logic                  empate_q, empate_d, tie_q, tie_d;
  logic [7:0]            m8;
  logic [IDX_W-1:0]      prim, prox;
  logic                  tem_prox, normal, abst_in, clr, inc;
`ifdef COLETOR_ABSTENCAO_EN
  assign abst_in = bus.abstem;
`else
  logic unused_abstem;
  assign unused_abstem = bus.abstem;
  assign abst_in = 1'b0;
`endif
  placar_votos #(.N(N_JOGADORES)) u_placar (
    .clk      (clock),
    .rst      (reset),
    .clr_i    (clr),
    .inc_i    (inc),
    .inc_idx_i(voto_q),
    .rd_idx_i (idx_q),
    .rd_cnt_o (cnt)
  );
  // Priority searches: lowest living player, and next living player above the current voter
  always_comb begin
    m8 = 8'(mask_q);
    prim = '0;
    prox = '0;
    tem_prox = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (m8[i]) prim = IDX_W'(i);
      if (m8[i] && i > int'(eleitor_q)) begin
        prox = IDX_W'(i);
        tem_prox = 1'b1;
      end
    end
  end
  assign normal = ({1'b0, bus.voto} < 4'(N_JOGADORES)) && m8[bus.voto] && bus.voto != eleitor_q;
  always_comb begin
    est_d = est_q;
    mask_d = mask_q;
    eleitor_d = eleitor_q;
    voto_d = voto_q;
    abst_d = abst_q;
    idx_d = idx_q;
    max_d = max_q;
    best_d = best_q;
    tie_d = tie_q;
    elim_d = elim_q;
    empate_d = empate_q;
    pronto_d = pronto_q;
    inval_d = 1'b0;
    clr = 1'b0;
    inc = 1'b0;
    case (est_q)
      INICIAL, FIM: if (bus.iniciar) begin
        mask_d = bus.vivos;
        clr = 1'b1;
        pronto_d = 1'b0;
        empate_d = 1'b0;
        elim_d = '0;
        idx_d = '0;
        max_d = '0;
        best_d = '0;
        tie_d = 1'b0;
        est_d = PREPARA;
      end
      PREPARA: begin
        eleitor_d = prim;
        est_d = |mask_q ? AGUARDA : APURA;
      end
      AGUARDA: if (bus.confirma) begin
        if (abst_in || normal) begin
          voto_d = bus.voto;
          abst_d = abst_in;
          est_d = REGISTRA;
        end else inval_d = 1'b1;
      end
      REGISTRA: begin
        inc = !abst_q;
        eleitor_d = tem_prox ? prox : eleitor_q;
        est_d = tem_prox ? AGUARDA : APURA;
      end
      APURA: begin
        if (cnt > max_q) begin
          max_d = cnt;
          best_d = idx_q;
          tie_d = 1'b0;
        end else if (cnt == max_q && max_q != '0) tie_d = 1'b1;
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(N_JOGADORES - 1)) begin
          est_d = FIM;
          pronto_d = 1'b1;
          empate_d = tie_d || max_d == '0;
          elim_d = max_d == '0 ? '0 : best_d;
        end
      end
      default: est_d = INICIAL;
    endcase
  end
  always_ff @(posedge clock)
    if (reset) begin
      est_q <= INICIAL;
      mask_q <= '0;
      eleitor_q <= '0;
      voto_q <= '0;
      abst_q <= 1'b0;
      idx_q <= '0;
      max_q <= '0;
      best_q <= '0;
      tie_q <= 1'b0;
      elim_q <= '0;
      empate_q <= 1'b0;
      pronto_q <= 1'b0;
      inval_q <= 1'b0;
    end else begin
      est_q <= est_d;
      mask_q <= mask_d;
      eleitor_q <= eleitor_d;
      voto_q <= voto_d;
      abst_q <= abst_d;
      idx_q <= idx_d;
      max_q <= max_d;
      best_q <= best_d;
      tie_q <= tie_d;
      elim_q <= elim_d;
      empate_q <= empate_d;
      pronto_q <= pronto_d;
      inval_q <= inval_d;
    end
  assign bus.eleitor_atual = eleitor_q;
  assign bus.voto_invalido = inval_q;
  assign bus.pronto = pronto_q;
  assign bus.eliminado = elim_q;
  assign bus.empate = empate_q;
  assign bus.db_estado = est_q;
endmodule

// File: tb/tb_coletor_votos.sv
// tb_coletor_votos: table-driven voting rounds scored by a pronto-triggered queue, plus hand-written corner sequences
module tb_coletor_votos;
  localparam int N = 8;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  coletor_votos_if #(.N(N)) b();
  coletor_votos_if #(.N(6)) b6();
  coletor_votos #(.N_JOGADORES(N)) dut (.clock(clock), .reset(reset), .bus(b.slave));
  coletor_votos #(.N_JOGADORES(6)) dut6 (.clock(clock), .reset(reset), .bus(b6.slave));
  typedef struct {
    logic [7:0]      vivos;
    logic [7:0][2:0] votos;
    logic            abst;
    logic            emp;
    logic            chk;
    logic [2:0]      elim;
  } rodada_t;
  typedef struct packed {
    logic       emp;
    logic       chk;
    logic [2:0] elim;
  } esp_t;
  rodada_t tab[8];
  esp_t    fila[$];
  esp_t    esp_m;
  int      pass_n = 0;
  int      total_n = 0;
  logic    pronto_ant = 1'b0;
  function automatic logic [7:0][2:0] vv(input int a0, a1, a2, a3, a4, a5, a6, a7);
    vv = {3'(a7), 3'(a6), 3'(a5), 3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction
  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esp);
    total_n++;
    if (atual === esp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d", nome, atual, esp);
  endtask
  task automatic falha(input string nome);
    total_n++;
    $display("FAIL %s: got timeout expected event", nome);
  endtask
  // Scoreboard: each rising pronto consumes one expected result
  always @(negedge clock) begin
    if (b.pronto && !pronto_ant) begin
      if (fila.size() == 0) falha("pronto_sem_rodada");
      else begin
        esp_m = fila.pop_front();
        chk("empate", 32'(b.empate), 32'(esp_m.emp));
        if (esp_m.chk) chk("eliminado", 32'(b.eliminado), 32'(esp_m.elim));
      end
    end
    pronto_ant <= b.pronto;
  end
  task automatic empurra(input logic emp, input logic c, input logic [2:0] elim);
    esp_t e;
    e.emp = emp;
    e.chk = c;
    e.elim = elim;
    fila.push_back(e);
  endtask
  task automatic inicia(input logic [7:0] v);
    b.vivos = v;
    b.iniciar = 1'b1;
    @(negedge clock);
    b.iniciar = 1'b0;
  endtask
  task automatic vota(input logic [2:0] v, input logic a);
    b.voto = v;
    b.abstem = a;
    b.confirma = 1'b1;
    @(negedge clock);
    b.confirma = 1'b0;
    b.abstem = 1'b0;
  endtask
  task automatic espera(input logic [4:0] est, input string nome, output logic ok);
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++)
      if (b.db_estado == est) ok = 1'b1;
      else @(negedge clock);
    if (!ok) falha(nome);
  endtask
  task automatic roda(input rodada_t r);
    logic ok;
    empurra(r.emp, r.chk, r.elim);
    inicia(r.vivos);
    for (int i = 0; i < 8; i++)
      if (r.vivos[i]) begin
        espera(5'd2, "aguarda", ok);
        if (!ok) return;
        chk("eleitor", 32'(b.eleitor_atual), 32'(i));
        vota(r.votos[i], r.abst);
      end
    espera(5'd5, "fim", ok);
  endtask
  initial begin
    logic ok;
    b.iniciar = 0; b.vivos = 0; b.voto = 0; b.abstem = 0; b.confirma = 0;
    b6.iniciar = 0; b6.vivos = 0; b6.voto = 0; b6.abstem = 0; b6.confirma = 0;
    tab[0] = '{8'h03, vv(1, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, 1'b0, 3'd0};
    tab[1] = '{8'hFF, vv(3, 3, 3, 1, 1, 0, 3, 3), 1'b0, 1'b0, 1'b1, 3'd3};
    tab[2] = '{8'h0F, vv(1, 0, 3, 2, 0, 0, 0, 0), 1'b0, 1'b1, 1'b0, 3'd0};
    tab[3] = '{8'h0F, vv(1, 0, 0, 1, 0, 0, 0, 0), 1'b0, 1'b1, 1'b0, 3'd0};
    tab[4] = '{8'hA6, vv(0, 5, 5, 0, 0, 7, 0, 5), 1'b0, 1'b0, 1'b1, 3'd5};
    tab[5] = '{8'h07, vv(2, 2, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0, 1'b1, 3'd2};
    tab[6] = '{8'hC0, vv(0, 0, 0, 0, 0, 0, 7, 6), 1'b0, 1'b1, 1'b0, 3'd0};
`ifdef COLETOR_ABSTENCAO_EN
    tab[7] = '{8'h07, vv(1, 2, 1, 0, 0, 0, 0, 0), 1'b1, 1'b1, 1'b1, 3'd0};
`else
    tab[7] = '{8'h07, vv(1, 2, 1, 0, 0, 0, 0, 0), 1'b1, 1'b0, 1'b1, 3'd1};
`endif
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_estado", 32'(b.db_estado), 0);
    chk("rst_eleitor", 32'(b.eleitor_atual), 0);
    chk("rst_pronto", 32'(b.pronto), 0);
    chk("rst_empate", 32'(b.empate), 0);
    chk("rst_eliminado", 32'(b.eliminado), 0);
    chk("rst_invalido", 32'(b.voto_invalido), 0);
    // Abort after three votes; reset must win over simultaneous iniciar/confirma
    inicia(8'hFF);
    espera(5'd2, "aguarda_r", ok);
    vota(3'd1, 1'b0);
    espera(5'd2, "aguarda_r", ok);
    vota(3'd0, 1'b0);
    espera(5'd2, "aguarda_r", ok);
    vota(3'd1, 1'b0);
    espera(5'd2, "aguarda_r", ok);
    chk("eleitor_antes_rst", 32'(b.eleitor_atual), 3);
    reset = 1'b1; b.iniciar = 1'b1; b.confirma = 1'b1; b.voto = 3'd5;
    @(negedge clock);
    reset = 1'b0; b.iniciar = 1'b0; b.confirma = 1'b0;
    chk("rst2_estado", 32'(b.db_estado), 0);
    chk("rst2_eleitor", 32'(b.eleitor_atual), 0);
    chk("rst2_pronto", 32'(b.pronto), 0);
    chk("rst2_empate", 32'(b.empate), 0);
    chk("rst2_eliminado", 32'(b.eliminado), 0);
    @(negedge clock);
    chk("rst2_ocioso", 32'(b.db_estado), 0);
    for (int k = 0; k < 8; k++) roda(tab[k]);
    // Empty mask: PREPARA, then exactly N APURA cycles, then FIM
    empurra(1'b1, 1'b1, 3'd0);
    inicia(8'h00);
    chk("vazio_prepara", 32'(b.db_estado), 1);
    @(negedge clock);
    chk("vazio_apura", 32'(b.db_estado), 4);
    repeat (N - 1) @(negedge clock);
    chk("vazio_apura_ult", 32'(b.db_estado), 4);
    chk("vazio_pronto_cedo", 32'(b.pronto), 0);
    @(negedge clock);
    chk("vazio_fim", 32'(b.db_estado), 5);
    chk("vazio_pronto", 32'(b.pronto), 1);
    chk("vazio_empate", 32'(b.empate), 1);
    chk("vazio_eliminado", 32'(b.eliminado), 0);
    // Rejected votes (dead target, self) must not reach the tally
    empurra(1'b0, 1'b1, 3'd5);
    inicia(8'hA6);
    espera(5'd2, "aguarda_i", ok);
    chk("inv_eleitor1", 32'(b.eleitor_atual), 1);
    vota(3'd0, 1'b0);
    chk("inv_morto", 32'(b.voto_invalido), 1);
    chk("inv_morto_est", 32'(b.db_estado), 2);
    chk("inv_morto_eleitor", 32'(b.eleitor_atual), 1);
    @(negedge clock);
    chk("inv_pulso", 32'(b.voto_invalido), 0);
    vota(3'd0, 1'b0);
    chk("inv_morto2", 32'(b.voto_invalido), 1);
    vota(3'd1, 1'b0);
    chk("inv_proprio1", 32'(b.voto_invalido), 1);
    vota(3'd2, 1'b0);
    chk("valido_registra", 32'(b.db_estado), 3);
    chk("valido_sem_pulso", 32'(b.voto_invalido), 0);
    espera(5'd2, "aguarda_i", ok);
    chk("inv_eleitor2", 32'(b.eleitor_atual), 2);
    vota(3'd2, 1'b0);
    chk("inv_proprio2", 32'(b.voto_invalido), 1);
    vota(3'd5, 1'b0);
    espera(5'd2, "aguarda_i", ok);
    chk("inv_eleitor5", 32'(b.eleitor_atual), 5);
    vota(3'd7, 1'b0);
    espera(5'd2, "aguarda_i", ok);
    chk("inv_eleitor7", 32'(b.eleitor_atual), 7);
    vota(3'd5, 1'b0);
    espera(5'd5, "fim_i", ok);
    // Six-player instance: indices 6 and 7 are out of range
    b6.vivos = 6'h3F;
    b6.iniciar = 1'b1;
    @(negedge clock);
    b6.iniciar = 1'b0;
    @(negedge clock);
    chk("n6_aguarda", 32'(b6.db_estado), 2);
    chk("n6_eleitor", 32'(b6.eleitor_atual), 0);
    for (int v = 6; v < 8; v++) begin
      b6.voto = 3'(v);
      b6.confirma = 1'b1;
      @(negedge clock);
      b6.confirma = 1'b0;
      chk("n6_fora", 32'(b6.voto_invalido), 1);
      chk("n6_fora_est", 32'(b6.db_estado), 2);
    end
    for (int i = 0; i < 6; i++) begin
      b6.voto = (i == 1) ? 3'd0 : 3'd1;
      b6.confirma = 1'b1;
      @(negedge clock);
      b6.confirma = 1'b0;
      @(negedge clock);
    end
    for (int t = 0; t < 30 && !b6.pronto; t++) @(negedge clock);
    if (!b6.pronto) falha("n6_pronto");
    else begin
      chk("n6_empate", 32'(b6.empate), 0);
      chk("n6_eliminado", 32'(b6.eliminado), 1);
    end
    for (int t = 0; t < 20 && fila.size() != 0; t++) @(negedge clock);
    if (fila.size() != 0) falha("fila_pendente");
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
